// File: rtl/uart_avs_sequencer.sv
// uart_avs_sequencer
//   Master-side sequencer for an Avalon-MM UART register slave. It polls the
//   status register, writes txdata when TRDY=1 and reads rxdata when RRDY=1.
//   TX and RX are arbitrated round-robin. It turns a valid/ready byte stream
//   on each side into single-cycle chipselect/read/write bus cycles.
//
//   Optional feature macro: UART_SEQ_ERR_EN
//     defined   : status error bits {ROE,BRK,FE,PE} = status[3:0] are OR'd into
//                 the sticky rx_err. Any set bit triggers one write of 0 to the
//                 status register before the pending grant is serviced.
//     undefined : rx_err is tied to 0, err_clr is ignored and status is never written.
//
// Ports
//   clk_50M, reset         clock, asynchronous active-high reset
//   tx_data/valid/ready    byte to send; tx_ready pulses with the txdata write
//   rx_data/valid/ready    received byte, held until the rx_valid&rx_ready handshake
//   rx_err, err_clr        sticky line-error flags and their clear
//   uart_ars_*             Avalon-MM master port towards the UART register slave
//
// State table
//   state     | meaning
//   IDLE      | gap countdown before the next status poll (0 = poll next cycle)
//   POLL      | read strobe to status (addr 2)
//   WAIT_ST   | wait READ_LATENCY cycles, capture status on the last one
//   DECIDE    | evaluate RX/TX candidates and round-robin grant
//   ST_CLR    | write 0 to status to clear error bits (error feature only)
//   WR_TX     | write tx_data to txdata (addr 1), tx_ready pulse
//   RD_RX     | read strobe to rxdata (addr 0)
//   WAIT_RX   | wait READ_LATENCY cycles, capture rx byte on the last one

module uart_avs_sequencer #(
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [3:0]        rx_err,
  input  logic              err_clr,
  output logic [2:0]        uart_ars_address,
  output logic              uart_ars_chipselect,
  output logic [3:0]        uart_ars_byteenable,
  output logic              uart_ars_read,
  output logic              uart_ars_write,
  output logic [31:0]       uart_ars_writedata,
  input  logic [31:0]       uart_ars_readdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POLL    = 3'd1;
  localparam logic [2:0] S_WAIT_ST = 3'd2;
  localparam logic [2:0] S_DECIDE  = 3'd3;
  localparam logic [2:0] S_WR_TX   = 3'd4;
  localparam logic [2:0] S_RD_RX   = 3'd5;
  localparam logic [2:0] S_WAIT_RX = 3'd6;
  localparam logic [2:0] S_ST_CLR  = 3'd7;

  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        status_q, status_d;
  logic              rr_tx_q, rr_tx_d;      // 1: last grant went to TX
  logic              gnt_tx_q, gnt_tx_d;    // grant parked across ST_CLR
  logic              gnt_any_q, gnt_any_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;

  logic rx_cand, tx_cand, pick_tx, err_pending;
  logic disp_en, disp_any, disp_tx;
  logic wr_tx, wr_clr, rd_st, rd_rx;

  assign rx_cand = status_q[7] & ~rx_valid_q;
  assign tx_cand = status_q[6] & tx_valid;
  assign pick_tx = (rx_cand & tx_cand) ? ~rr_tx_q : tx_cand;

`ifdef UART_SEQ_ERR_EN
  assign err_pending = |status_q[3:0];
`else
  assign err_pending = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    gap_d      = gap_q;
    status_d   = status_q;
    rr_tx_d    = rr_tx_q;
    gnt_tx_d   = gnt_tx_q;
    gnt_any_d  = gnt_any_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    disp_en    = 1'b0;
    disp_any   = 1'b0;
    disp_tx    = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gap_q == '0) state_d = S_POLL;
        else             gap_d   = gap_q - 1'b1;
      end
      S_POLL: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT_ST;
      end
      S_WAIT_ST: begin
        if (lat_q == '0) begin
          status_d = uart_ars_readdata[7:0];
          state_d  = S_DECIDE;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_DECIDE: begin
        if (rx_cand || tx_cand) rr_tx_d = pick_tx;
        gnt_tx_d  = pick_tx;
        gnt_any_d = rx_cand | tx_cand;
        if (err_pending) begin
          state_d = S_ST_CLR;
        end else begin
          disp_en  = 1'b1;
          disp_any = rx_cand | tx_cand;
          disp_tx  = pick_tx;
        end
      end
      S_ST_CLR: begin
        disp_en  = 1'b1;
        disp_any = gnt_any_q;
        disp_tx  = gnt_tx_q;
      end
      S_WR_TX: begin
        state_d = S_IDLE;
        gap_d   = '0;
      end
      S_RD_RX: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (lat_q == '0) begin
          rx_data_d  = uart_ars_readdata[DATA_W-1:0];
          rx_valid_d = 1'b1;
          state_d    = S_IDLE;
          gap_d      = '0;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared dispatch: a transfer runs immediately, an empty decision waits POLL_GAP cycles.
    if (disp_en) begin
      if (disp_any) begin
        state_d = disp_tx ? S_WR_TX : S_RD_RX;
      end else if (POLL_GAP == 0) begin
        state_d = S_POLL;
      end else begin
        state_d = S_IDLE;
        gap_d   = GAP_INIT;
      end
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      gap_q      <= '0;
      status_q   <= '0;
      rr_tx_q    <= 1'b0;
      gnt_tx_q   <= 1'b0;
      gnt_any_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      gap_q      <= gap_d;
      status_q   <= status_d;
      rr_tx_q    <= rr_tx_d;
      gnt_tx_q   <= gnt_tx_d;
      gnt_any_q  <= gnt_any_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // Strobes decode straight from the state so an async reset removes them at once.
  // The txdata write also requires tx_valid, so a withdrawn request issues nothing.
  assign rd_st  = (state_q == S_POLL);
  assign rd_rx  = (state_q == S_RD_RX);
  assign wr_tx  = (state_q == S_WR_TX) & tx_valid;
  assign wr_clr = (state_q == S_ST_CLR);

  assign uart_ars_read       = rd_st | rd_rx;
  assign uart_ars_write      = wr_tx | wr_clr;
  assign uart_ars_chipselect = uart_ars_read | uart_ars_write;
  assign uart_ars_byteenable = 4'b1111;
  assign uart_ars_address    = rd_rx ? 3'd0 : (state_q == S_WR_TX) ? 3'd1 : 3'd2;
  assign uart_ars_writedata  = wr_tx ? {{(32-DATA_W){1'b0}}, tx_data} : 32'h0;

  assign tx_ready = wr_tx;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

`ifdef UART_SEQ_ERR_EN
  logic [3:0] rx_err_q, rx_err_d;

  // A clear and a fresh error in the same cycle: the fresh error survives.
  always_comb begin
    rx_err_d = err_clr ? 4'b0 : rx_err_q;
    if (state_q == S_DECIDE) rx_err_d = rx_err_d | status_q[3:0];
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) rx_err_q <= 4'b0;
    else       rx_err_q <= rx_err_d;
  end

  assign rx_err = rx_err_q;

  logic unused_sink;
  assign unused_sink = ^{status_q[5:4], uart_ars_readdata[31:DATA_W]};
`else
  assign rx_err = 4'b0;

  logic unused_sink;
  assign unused_sink = ^{err_clr, status_q[5:0], uart_ars_readdata[31:DATA_W]};
`endif

endmodule

// File: tb/tb_uart_avs_sequencer.sv
module tb_uart_avs_sequencer;

  localparam int RL  = 1;
  localparam int GAP = 4;
  localparam int DW  = 8;

  logic          clk_50M = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [3:0]    rx_err;
  logic          err_clr;
  logic [2:0]    uart_ars_address;
  logic          uart_ars_chipselect;
  logic [3:0]    uart_ars_byteenable;
  logic          uart_ars_read;
  logic          uart_ars_write;
  logic [31:0]   uart_ars_writedata;
  logic [31:0]   uart_ars_readdata;

  uart_avs_sequencer #(.READ_LATENCY(RL), .POLL_GAP(GAP), .DATA_W(DW)) dut (
    .clk_50M             (clk_50M),
    .reset               (reset),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .rx_err              (rx_err),
    .err_clr             (err_clr),
    .uart_ars_address    (uart_ars_address),
    .uart_ars_chipselect (uart_ars_chipselect),
    .uart_ars_byteenable (uart_ars_byteenable),
    .uart_ars_read       (uart_ars_read),
    .uart_ars_write      (uart_ars_write),
    .uart_ars_writedata  (uart_ars_writedata),
    .uart_ars_readdata   (uart_ars_readdata)
  );

  always #5 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline model: absolute cycle numbers of the next expected bus events.
  int            cyc = 0;
  int            exp_poll_at, exp_decide_at, exp_tx_at, exp_rx_at, exp_clr_at, exp_cap_at;
  int            rd_due;
  logic [31:0]   rd_val;
  logic [31:0]   st_val;
  logic          m_rx_valid;
  logic [DW-1:0] m_rx_data;
  logic          m_rr_tx;
  logic [3:0]    m_err, nerr;
  logic          tx_done = 1'b0;
  int            rst_kind = 0;
  int            rst_hold = 0;
  int            n_tx = 0, n_rx = 0, n_clr = 0, n_poll = 0, n_rst = 0;

  function automatic int phase_of(input int c);
    if (c < 800)  return 0;   // random traffic
    if (c < 1100) return 1;   // rx byte left unconsumed
    if (c < 1400) return 2;   // both directions ready on every poll
    if (c < 1700) return 3;   // nothing pending
    return 0;
  endfunction

  task automatic model_reset();
    exp_poll_at   = -1;
    exp_decide_at = -1;
    exp_tx_at     = -1;
    exp_rx_at     = -1;
    exp_clr_at    = -1;
    exp_cap_at    = -1;
    rd_due        = -1;
    rd_val        = 32'h0;
    st_val        = 32'h0;
    m_rx_valid    = 1'b0;
    m_rx_data     = '0;
    m_rr_tx       = 1'b0;
    m_err         = 4'b0;
  endtask

  function automatic logic [31:0] gen_status(input int ph);
    logic [31:0] s;
    s = $urandom;
`ifdef UART_SEQ_ERR_EN
    if (ph != 0 || $urandom_range(0, 5) != 0) s[3:0] = 4'b0;
`endif
    case (ph)
      1:       begin s[7] = 1'b1; s[6] = 1'($urandom_range(0, 1)); end
      2:       s[7:6] = 2'b11;
      3:       s[7:6] = 2'b00;
      default: begin s[7] = 1'($urandom_range(0, 1)); s[6] = 1'($urandom_range(0, 1)); end
    endcase
    return s;
  endfunction

  task automatic drive_inputs();
    int ph;
    ph = phase_of(cyc);
    if (tx_done) begin
      tx_valid = 1'b0;
      tx_done  = 1'b0;
    end
    case (ph)
      2: begin
        if (!tx_valid) begin
          tx_valid = 1'b1;
          tx_data  = $urandom_range(0, 1) != 0 ? DW'(8'hA5) : DW'($urandom);
        end
        rx_ready = 1'b1;
      end
      3: begin
        tx_valid = 1'b0;
        rx_ready = 1'($urandom_range(0, 1));
      end
      default: begin
        if (!tx_valid && $urandom_range(0, 3) == 0) begin
          tx_valid = 1'b1;
          tx_data  = DW'($urandom);
        end else if (tx_valid && $urandom_range(0, 39) == 0) begin
          tx_valid = 1'b0;
        end
        rx_ready = (ph == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
      end
    endcase
    err_clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic decide();
    logic rxc, txc, gtx;
    int   base;
    rxc  = st_val[7] && !m_rx_valid;
    txc  = st_val[6] && tx_valid;
    base = cyc + 1;
`ifdef UART_SEQ_ERR_EN
    nerr = nerr | st_val[3:0];
    if (st_val[3:0] != 4'b0) begin
      exp_clr_at = base;
      base++;
    end
`endif
    gtx = (rxc && txc) ? !m_rr_tx : txc;
    if (rxc || txc) begin
      m_rr_tx = gtx;
      if (gtx) begin
        exp_tx_at   = base;
        exp_poll_at = base + 2;
      end else begin
        exp_rx_at   = base;
        exp_poll_at = base + RL + 2;
      end
    end else begin
      exp_poll_at = base + GAP;
    end
  endtask

  task automatic model_cycle();
    logic        e_rd, e_wtx, e_wclr, e_rx;
    logic [31:0] e_wd;
    e_rx   = (cyc == exp_rx_at);
    e_rd   = (cyc == exp_poll_at) || e_rx;
    e_wtx  = (cyc == exp_tx_at) && tx_valid;
    e_wclr = (cyc == exp_clr_at);
    check_eq("read", 32'(uart_ars_read), 32'(e_rd));
    check_eq("write", 32'(uart_ars_write), 32'(e_wtx | e_wclr));
    check_eq("chipselect", 32'(uart_ars_chipselect), 32'(e_rd | e_wtx | e_wclr));
    check_eq("byteenable", 32'(uart_ars_byteenable), 32'hF);
    check_eq("tx_ready", 32'(tx_ready), 32'(e_wtx));
    if (e_rd || e_wtx || e_wclr)
      check_eq("address", 32'(uart_ars_address), e_rx ? 32'd0 : e_wtx ? 32'd1 : 32'd2);
    if (e_wtx || e_wclr) begin
      e_wd = 32'h0;
      if (e_wtx) e_wd[DW-1:0] = tx_data;
      check_eq("writedata", uart_ars_writedata, e_wd);
    end
    check_eq("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
    check_eq("rx_data", 32'(rx_data), 32'(m_rx_data));
    check_eq("rx_err", 32'(rx_err), 32'(m_err));

    if (tx_ready) tx_done = 1'b1;
    if (e_wtx)  n_tx++;
    if (e_rx)   n_rx++;
    if (e_wclr) n_clr++;

    if (cyc == exp_poll_at) begin
      st_val        = gen_status(phase_of(cyc));
      rd_val        = st_val;
      rd_due        = cyc + RL;
      exp_decide_at = cyc + RL + 1;
      n_poll++;
    end
    if (e_rx) begin
      rd_val     = $urandom;
      rd_due     = cyc + RL;
      exp_cap_at = cyc + RL;
    end

    nerr = err_clr ? 4'b0 : m_err;
    if (cyc == exp_decide_at) decide();
`ifdef UART_SEQ_ERR_EN
    m_err = nerr;
`endif
    if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
    if (cyc == exp_cap_at) begin
      m_rx_valid = 1'b1;
      m_rx_data  = rd_val[DW-1:0];
    end
  endtask

  initial begin
    reset             = 1'b1;
    tx_data           = '0;
    tx_valid          = 1'b0;
    rx_ready          = 1'b0;
    err_clr           = 1'b0;
    uart_ars_readdata = 32'h0;
    model_reset();
    rst_hold = 3;

    @(negedge clk_50M);
    check_eq("rst_read", 32'(uart_ars_read), 32'd0);
    check_eq("rst_write", 32'(uart_ars_write), 32'd0);
    check_eq("rst_cs", 32'(uart_ars_chipselect), 32'd0);
    check_eq("rst_addr", 32'(uart_ars_address), 32'd2);
    check_eq("rst_wdata", uart_ars_writedata, 32'h0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_err", 32'(rx_err), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_50M);
      #1;
      cyc++;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) begin
          reset = 1'b0;
          model_reset();
          exp_poll_at = cyc + 1;
        end
      end
      drive_inputs();
      uart_ars_readdata = (cyc == rd_due) ? rd_val : ~rd_val;
      if (cyc == 1000) rst_kind = 1;
      if (cyc == 1300) rst_kind = 2;

      if (!reset && rst_kind != 0 &&
          ((rst_kind == 1 && exp_decide_at == cyc + 1) ||
           (rst_kind == 2 && exp_tx_at == cyc && tx_valid))) begin
        #1 reset = 1'b1;
        #1;
        check_eq("midrst_read", 32'(uart_ars_read), 32'd0);
        check_eq("midrst_write", 32'(uart_ars_write), 32'd0);
        check_eq("midrst_cs", 32'(uart_ars_chipselect), 32'd0);
        check_eq("midrst_tx_ready", 32'(tx_ready), 32'd0);
        check_eq("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("midrst_addr", 32'(uart_ars_address), 32'd2);
        rst_kind = 0;
        rst_hold = 3;
        n_rst++;
      end

      @(negedge clk_50M);
      if (!reset) model_cycle();
    end

    check_eq("tx_transfers_seen", 32'(n_tx > 0), 32'd1);
    check_eq("rx_transfers_seen", 32'(n_rx > 0), 32'd1);
    check_eq("polls_seen", 32'(n_poll > 100), 32'd1);
    check_eq("mid_resets_done", 32'(n_rst), 32'd2);
`ifdef UART_SEQ_ERR_EN
    check_eq("status_clears_seen", 32'(n_clr > 0), 32'd1);
`else
    check_eq("status_clears_none", 32'(n_clr), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
